// File: rtl/prim_pkg.sv
// Shared types for the prim packer/unpacker blocks: flush FSM encodings and width helpers.
package prim_pkg;

  typedef enum logic [1:0] {
    PackIdle,
    PackPad,
    PackDrain
  } pack_flush_e;

  typedef enum logic {
    UnpackIdle,
    UnpackDrain
  } unpack_flush_e;

  // Index width for a lane selector; a single lane still needs one bit.
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prim_lane_lzd.sv
// Priority encoder: index of the lowest set lane-valid bit plus an any-valid flag.
// Purely combinational, no latency and no backpressure.
module prim_lane_lzd
  import prim_pkg::*;
#(
  parameter int NumLanes = 4,
  parameter int IdxW     = idx_width(NumLanes)
) (
  input  logic [NumLanes-1:0] lane_vld_i,
  output logic [IdxW-1:0]     idx_o,
  output logic                any_vld_o
);

  // Scan from the top so the lowest-indexed set bit wins.
  always_comb begin
    idx_o = '0;
    for (int k = NumLanes - 1; k >= 0; k--) begin
      if (lane_vld_i[k]) begin
        idx_o = IdxW'(k);
      end
    end
  end

  assign any_vld_o = |lane_vld_i;

endmodule

// File: rtl/prim_unpacker.sv
// Splits masked InW words into OutW lanes, skipping empty lanes; first lane one cycle after accept.
// Accepts a new word only when empty or on the final lane's ack; flush blocks input until drained.
module prim_unpacker
  import prim_pkg::*;
#(
  parameter int InW  = 32,
  parameter int OutW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  input  logic [InW-1:0]  data_i,
  input  logic [InW-1:0]  mask_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [OutW-1:0] data_o,
  output logic [OutW-1:0] mask_o,
  input  logic            ready_i,
  input  logic            flush_i,
  output logic            flush_done_o
);

  localparam int NumLanes = InW / OutW;
  localparam int IdxW     = idx_width(NumLanes);

  logic [InW-1:0]      data_q, data_d;
  logic [InW-1:0]      mask_q, mask_d;
  unpack_flush_e       state_q, state_d;
  logic [NumLanes-1:0] lane_live;
  logic [IdxW-1:0]     lane_idx;
  logic                any_live;
  logic                one_live;
  logic                ack_in;
  logic                ack_out;

  for (genvar k = 0; k < NumLanes; k++) begin : g_live
    assign lane_live[k] = |mask_q[k*OutW +: OutW];
  end

  prim_lane_lzd #(
    .NumLanes (NumLanes),
    .IdxW     (IdxW)
  ) u_lzd (
    .lane_vld_i (lane_live),
    .idx_o      (lane_idx),
    .any_vld_o  (any_live)
  );

  assign one_live = any_live && ((lane_live & (lane_live - NumLanes'(1))) == '0);
  assign valid_o  = any_live;
  assign ack_out  = valid_o & ready_i;
  assign ready_o  = (state_q == UnpackIdle) && (!any_live || (one_live && ready_i));
  assign ack_in   = valid_i & ready_o;

  always_comb begin
    data_o = '0;
    mask_o = '0;
    for (int k = 0; k < NumLanes; k++) begin
      if (IdxW'(k) == lane_idx) begin
        data_o = data_q[k*OutW +: OutW];
        mask_o = mask_q[k*OutW +: OutW];
      end
    end
  end

  always_comb begin
    data_d       = data_q;
    mask_d       = mask_q;
    state_d      = state_q;
    flush_done_o = 1'b0;

    if (ack_out) begin
      for (int k = 0; k < NumLanes; k++) begin
        if (IdxW'(k) == lane_idx) begin
          mask_d[k*OutW +: OutW] = '0;
        end
      end
    end
    // A new word replaces whatever the final-lane clear left behind.
    if (ack_in) begin
      data_d = data_i;
      mask_d = mask_i;
    end

    unique case (state_q)
      UnpackIdle: begin
        if (flush_i) begin
          if (!any_live) begin
            flush_done_o = 1'b1;
          end else begin
            state_d = UnpackDrain;
          end
        end
      end
      UnpackDrain: begin
        // Input is blocked here, so mask_d reflects only the lane clear.
        if (mask_d == '0) begin
          flush_done_o = 1'b1;
          state_d      = UnpackIdle;
        end
      end
      default: state_d = UnpackIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      mask_q  <= '0;
      state_q <= UnpackIdle;
    end else begin
      data_q  <= data_d;
      mask_q  <= mask_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_prim_unpacker.sv
// Directed bench for prim_unpacker: ordering, skipping, stalls, flush handshake and reset.
module tb_prim_unpacker;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic [31:0] data_i;
  logic [31:0] mask_i;
  logic        ready_o;
  logic        valid_o;
  logic [7:0]  data_o;
  logic [7:0]  mask_o;
  logic        ready_i;
  logic        flush_i;
  logic        flush_done_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] lanes [4];

  always #5 clk_i = ~clk_i;

  prim_unpacker #(.InW(32), .OutW(8)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .mask_i       (mask_i),
    .ready_o      (ready_o),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .mask_o       (mask_o),
    .ready_i      (ready_i),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    lanes[0] = 8'hAA; lanes[1] = 8'hBB; lanes[2] = 8'hCC; lanes[3] = 8'hDD;
    rst_ni = 1'b0; valid_i = 1'b0; data_i = '0; mask_i = '0; ready_i = 1'b0; flush_i = 1'b0;
    #3;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data", 32'(data_o), 32'h0);
    check("rst_mask", 32'(mask_o), 32'h0);
    check("rst_done", 32'(flush_done_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    tick();
    rst_ni = 1'b1;
    tick();

    // Full word, ready held high, followed back-to-back by a second word.
    valid_i = 1'b1; data_i = 32'hDDCCBBAA; mask_i = 32'hFFFFFFFF; ready_i = 1'b1;
    settle();
    check("full_accept_ready", 32'(ready_o), 32'd1);
    tick();
    valid_i = 1'b0;
    settle();
    check("full_l0_valid", 32'(valid_o), 32'd1);
    check("full_l0_data", 32'(data_o), 32'hAA);
    check("full_l0_mask", 32'(mask_o), 32'hFF);
    check("full_l0_ready", 32'(ready_o), 32'd0);
    tick(); settle();
    check("full_l1_data", 32'(data_o), 32'hBB);
    tick(); settle();
    check("full_l2_data", 32'(data_o), 32'hCC);
    check("full_l2_ready", 32'(ready_o), 32'd0);
    tick();
    valid_i = 1'b1; data_i = 32'h88776655; mask_i = 32'hFFFFFFFF;
    settle();
    check("full_l3_data", 32'(data_o), 32'hDD);
    check("full_l3_ready", 32'(ready_o), 32'd1);
    tick();
    valid_i = 1'b0;
    settle();
    check("b2b_l0_valid", 32'(valid_o), 32'd1);
    check("b2b_l0_data", 32'(data_o), 32'h55);
    tick(); settle();
    check("b2b_l1_data", 32'(data_o), 32'h66);
    tick(); settle();
    check("b2b_l2_data", 32'(data_o), 32'h77);
    tick(); settle();
    check("b2b_l3_data", 32'(data_o), 32'h88);
    tick(); settle();
    check("b2b_empty_valid", 32'(valid_o), 32'd0);
    check("b2b_empty_ready", 32'(ready_o), 32'd1);

    // Sparse mask: only lanes 0 and 2 carry data.
    tick();
    valid_i = 1'b1; data_i = 32'h44332211; mask_i = 32'h00FF00FF;
    tick();
    valid_i = 1'b0;
    settle();
    check("skip_l0_data", 32'(data_o), 32'h11);
    check("skip_l0_mask", 32'(mask_o), 32'hFF);
    check("skip_l0_ready", 32'(ready_o), 32'd0);
    tick(); settle();
    check("skip_l2_valid", 32'(valid_o), 32'd1);
    check("skip_l2_data", 32'(data_o), 32'h33);
    check("skip_l2_ready", 32'(ready_o), 32'd1);
    tick(); settle();
    check("skip_end_valid", 32'(valid_o), 32'd0);

    // Downstream stalls every other cycle: each lane shows for two cycles.
    tick();
    valid_i = 1'b1; data_i = 32'hDDCCBBAA; mask_i = 32'hFFFFFFFF;
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ready_i = (i % 2 == 1);
      settle();
      check($sformatf("stall_c%0d_valid", i), 32'(valid_o), 32'd1);
      check($sformatf("stall_c%0d_data", i), 32'(data_o), 32'(lanes[i/2]));
      tick();
    end
    settle();
    check("stall_end_valid", 32'(valid_o), 32'd0);

    // All-zero mask is accepted but yields nothing.
    ready_i = 1'b1;
    tick();
    valid_i = 1'b1; data_i = 32'h12345678; mask_i = 32'h0;
    settle();
    check("zero_accept_ready", 32'(ready_o), 32'd1);
    tick();
    valid_i = 1'b0;
    settle();
    check("zero_valid", 32'(valid_o), 32'd0);
    check("zero_ready", 32'(ready_o), 32'd1);
    tick(); settle();
    check("zero_valid2", 32'(valid_o), 32'd0);

    // Flush with two lanes (2 and 3) live, then flush while empty.
    tick();
    valid_i = 1'b1; data_i = 32'hDDCCBBAA; mask_i = 32'hFFFF0000; ready_i = 1'b0;
    tick();
    valid_i = 1'b0; flush_i = 1'b1;
    settle();
    check("fl_req_data", 32'(data_o), 32'hCC);
    check("fl_req_ready", 32'(ready_o), 32'd0);
    check("fl_req_done", 32'(flush_done_o), 32'd0);
    tick();
    flush_i = 1'b0;
    settle();
    check("fl_stall_ready", 32'(ready_o), 32'd0);
    check("fl_stall_data", 32'(data_o), 32'hCC);
    check("fl_stall_done", 32'(flush_done_o), 32'd0);
    tick();
    ready_i = 1'b1;
    settle();
    check("fl_ack1_data", 32'(data_o), 32'hCC);
    check("fl_ack1_done", 32'(flush_done_o), 32'd0);
    check("fl_ack1_ready", 32'(ready_o), 32'd0);
    tick(); settle();
    check("fl_ack2_data", 32'(data_o), 32'hDD);
    check("fl_ack2_done", 32'(flush_done_o), 32'd1);
    check("fl_ack2_ready", 32'(ready_o), 32'd0);
    tick(); settle();
    check("fl_post_valid", 32'(valid_o), 32'd0);
    check("fl_post_done", 32'(flush_done_o), 32'd0);
    check("fl_post_ready", 32'(ready_o), 32'd1);
    flush_i = 1'b1;
    #1;
    check("fl_empty_done", 32'(flush_done_o), 32'd1);
    check("fl_empty_ready", 32'(ready_o), 32'd1);
    tick();
    flush_i = 1'b0;
    settle();
    check("fl_empty_done_clr", 32'(flush_done_o), 32'd0);

    // Reset while lane 2 of a full word is on the output.
    tick();
    valid_i = 1'b1; data_i = 32'hDDCCBBAA; mask_i = 32'hFFFFFFFF; ready_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    tick(); settle();
    check("rstmid_l2_data", 32'(data_o), 32'hCC);
    rst_ni = 1'b0;
    #1;
    check("rstmid_valid", 32'(valid_o), 32'd0);
    check("rstmid_ready", 32'(ready_o), 32'd1);
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("rstmid_after%0d_valid", i), 32'(valid_o), 32'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
